// File: rtl/stdin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stdin_pkg
// Description : Shared constants, parser state and byte classifier for the
//               console receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package stdin_pkg;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_EOT = 8'h04;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } stdin_state_e;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_SEP   = 2'd1,
        CLS_EOT   = 2'd2,
        CLS_OTHER = 2'd3
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        if (b >= ASCII_0 && b <= ASCII_9)
            return CLS_DIGIT;
        else if (b == ASCII_SP || b == ASCII_TAB || b == ASCII_LF || b == ASCII_CR)
            return CLS_SEP;
        else if (b == ASCII_EOT)
            return CLS_EOT;
        else
            return CLS_OTHER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stdin_if.sv
`default_nettype none
// ============================================================================
// Module      : stdin_if
// Description : UART byte input, parsed-word output, EOF/error and LCD echo
//               signals of the console receive path.
// Revision    : 1.0 - initial release
// ============================================================================
interface stdin_if;
    logic        uart_val_i;
    logic [7:0]  uart_data_i;
    logic        uart_rdy_o;
    logic        stdin_val_o;
    logic [15:0] stdin_data_o;
    logic        stdin_rdy_i;
    logic        stdin_eof_o;
    logic        stdin_clear_i;
    logic        err_o;
    logic [3:0]  lcd_bcd_o [0:3];

    // Environment side: UART receiver, TOY core and LCD
    modport master (
        output uart_val_i, uart_data_i, stdin_rdy_i, stdin_clear_i,
        input  uart_rdy_o, stdin_val_o, stdin_data_o, stdin_eof_o, err_o, lcd_bcd_o
    );

    // Parser side
    modport slave (
        input  uart_val_i, uart_data_i, stdin_rdy_i, stdin_clear_i,
        output uart_rdy_o, stdin_val_o, stdin_data_o, stdin_eof_o, err_o, lcd_bcd_o
    );
endinterface
`default_nettype wire

// File: rtl/stdin_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stdin_fifo
// Description : Synchronous show-ahead FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stdin_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL_CNT  = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Memory is cleared on reset so the head reads zero before the first push
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == C_FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_head  = r_mem[r_rd_ptr];
endmodule
`default_nettype wire

// File: rtl/stdin.sv
`default_nettype none
// ============================================================================
// Module      : stdin
// Description : Parses UART ASCII into decimal 16-bit words, buffers them for
//               the core and echoes typed digits to the LCD.
// Revision    : 1.0 - initial release
// ============================================================================
module stdin
    import stdin_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int DEPTH      = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    stdin_if.slave  bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    stdin_state_e r_state;
    stdin_state_e w_next_state;
    byte_class_e  w_class;
    logic [3:0]   w_digit;
    logic         w_hs;
    logic         w_cnt_max;
    logic         w_first;
    logic         w_shift;
    logic         w_push;
    logic         w_set_eof;
    logic         w_err;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [15:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [3:0]   r_lcd [0:3];
    logic         r_eof;
    logic         r_err;

    assign w_hs      = bus.uart_val_i & bus.uart_rdy_o;
    assign w_class   = classify(bus.uart_data_i);
    assign w_digit   = bus.uart_data_i[3:0];
    assign w_cnt_max = (r_cnt == CW'(MAX_DIGITS));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_hs) begin
            case (r_state)
                IDLE: begin
                    if (w_class == CLS_DIGIT)      w_next_state = ACCUM;
                    else if (w_class == CLS_OTHER) w_next_state = DISCARD;
                end
                ACCUM: begin
                    if (w_class == CLS_SEP || w_class == CLS_EOT) w_next_state = IDLE;
                    else if (w_class == CLS_OTHER || w_cnt_max)   w_next_state = DISCARD;
                end
                DISCARD: begin
                    if (w_class == CLS_SEP || w_class == CLS_EOT) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_first   = 1'b0;
        w_shift   = 1'b0;
        w_push    = 1'b0;
        w_set_eof = 1'b0;
        w_err     = 1'b0;
        if (w_hs) begin
            case (r_state)
                IDLE: begin
                    w_first   = (w_class == CLS_DIGIT);
                    w_set_eof = (w_class == CLS_EOT);
                    w_err     = (w_class == CLS_OTHER);
                end
                ACCUM: begin
                    w_shift   = (w_class == CLS_DIGIT) && !w_cnt_max;
                    w_err     = (w_class == CLS_OTHER) || ((w_class == CLS_DIGIT) && w_cnt_max);
                    w_push    = (w_class == CLS_SEP) || (w_class == CLS_EOT);
                    w_set_eof = (w_class == CLS_EOT);
                end
                DISCARD: w_set_eof = (w_class == CLS_EOT);
                default: w_err = 1'b0;
            endcase
        end
    end

    // A same-cycle EOT wins over a clear request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_eof <= 1'b0;
            r_err <= 1'b0;
            for (int i = 0; i < 4; i++) r_lcd[i] <= '0;
        end else begin
            r_err <= w_err;
            if (w_first) begin
                r_acc    <= {12'd0, w_digit};
                r_cnt    <= CW'(1);
                r_lcd[0] <= w_digit;
                r_lcd[1] <= '0;
                r_lcd[2] <= '0;
                r_lcd[3] <= '0;
            end else if (w_shift) begin
                r_acc    <= (r_acc * 16'd10) + {12'd0, w_digit};
                r_cnt    <= r_cnt + CW'(1);
                r_lcd[0] <= w_digit;
                r_lcd[1] <= r_lcd[0];
                r_lcd[2] <= r_lcd[1];
                r_lcd[3] <= r_lcd[2];
            end
            if (w_set_eof)              r_eof <= 1'b1;
            else if (bus.stdin_clear_i) r_eof <= 1'b0;
        end
    end

    stdin_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (r_acc),
        .i_pop   (bus.stdin_rdy_i),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (bus.stdin_data_o)
    );

    assign bus.uart_rdy_o  = ~w_fifo_full;
    assign bus.stdin_val_o = ~w_fifo_empty;
    assign bus.stdin_eof_o = r_eof;
    assign bus.err_o       = r_err;

    for (genvar i = 0; i < 4; i++) begin : g_lcd
        assign bus.lcd_bcd_o[i] = r_lcd[i];
    end
endmodule
`default_nettype wire

// File: tb/tb_stdin.sv
`default_nettype none
// ============================================================================
// Module      : tb_stdin
// Description : Self-checking bench for stdin with a word scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stdin;
    import stdin_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    stdin_if u_if();

    stdin #(.MAX_DIGITS(4), .DEPTH(4)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (u_if)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_pop  = 0;
    int n_err  = 0;
    int n_acc  = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    // Scoreboard: every word the core takes is checked against the queue head
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (u_if.uart_val_i && u_if.uart_rdy_o) n_acc++;
            if (u_if.err_o) n_err++;
            if (u_if.stdin_val_o && u_if.stdin_rdy_i) begin
                n_pop++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL pop_unexpected: got word %0d, expected no word", u_if.stdin_data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (u_if.stdin_data_o !== mon_exp) begin
                        n_miss++;
                        $display("FAIL pop_data: got %0d, expected %0d", u_if.stdin_data_o, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        u_if.uart_val_i  = 1'b1;
        u_if.uart_data_i = b;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_i);
            done = u_if.uart_rdy_o;
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL uart_timeout: byte 0x%02h not accepted, expected accept within 100 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle_uart();
        u_if.uart_val_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni             = 1'b0;
        u_if.uart_val_i    = 1'b0;
        u_if.uart_data_i   = 8'h00;
        u_if.stdin_rdy_i   = 1'b0;
        u_if.stdin_clear_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        n_vec++; if (u_if.stdin_val_o !== 1'b0) begin n_miss++; $display("FAIL rst_val: got %b, expected 0", u_if.stdin_val_o); end
        n_vec++; if (u_if.stdin_data_o !== 16'd0) begin n_miss++; $display("FAIL rst_data: got %0d, expected 0", u_if.stdin_data_o); end
        n_vec++; if (u_if.stdin_eof_o !== 1'b0) begin n_miss++; $display("FAIL rst_eof: got %b, expected 0", u_if.stdin_eof_o); end
        n_vec++; if (u_if.err_o !== 1'b0) begin n_miss++; $display("FAIL rst_err: got %b, expected 0", u_if.err_o); end
        n_vec++; if (u_if.uart_rdy_o !== 1'b1) begin n_miss++; $display("FAIL rst_uart_rdy: got %b, expected 1", u_if.uart_rdy_o); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (u_if.lcd_bcd_o[i] !== 4'd0) begin n_miss++; $display("FAIL rst_lcd%0d: got %0d, expected 0", i, u_if.lcd_bcd_o[i]); end
        end
    endtask

    task automatic test_single_word();
        int p0;
        u_if.stdin_rdy_i = 1'b1;
        p0 = n_pop;
        exp_q.push_back(16'd123);
        send_str("123\n");
        idle_uart();
        n_vec++; if (u_if.stdin_val_o !== 1'b1) begin n_miss++; $display("FAIL latency_val: got %b, expected 1", u_if.stdin_val_o); end
        n_vec++; if (u_if.stdin_data_o !== 16'd123) begin n_miss++; $display("FAIL latency_data: got %0d, expected 123", u_if.stdin_data_o); end
        wait_cycles(3);
        n_vec++; if (n_pop - p0 !== 1) begin n_miss++; $display("FAIL single_pops: got %0d, expected 1", n_pop - p0); end
        n_vec++; if (u_if.stdin_val_o !== 1'b0) begin n_miss++; $display("FAIL single_val_drop: got %b, expected 0", u_if.stdin_val_o); end
        n_vec++; if (u_if.lcd_bcd_o[3] !== 4'd0 || u_if.lcd_bcd_o[2] !== 4'd1 || u_if.lcd_bcd_o[1] !== 4'd2 || u_if.lcd_bcd_o[0] !== 4'd3) begin
            n_miss++;
            $display("FAIL lcd_123: got %0d%0d%0d%0d, expected 0123", u_if.lcd_bcd_o[3], u_if.lcd_bcd_o[2], u_if.lcd_bcd_o[1], u_if.lcd_bcd_o[0]);
        end
    endtask

    task automatic test_fill_drain();
        int p0;
        u_if.stdin_rdy_i = 1'b0;
        p0 = n_pop;
        exp_q.push_back(16'd9999);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd42);
        send_str("9999 0 42\r");
        idle_uart();
        wait_cycles(2);
        n_vec++; if (u_if.stdin_val_o !== 1'b1 || u_if.stdin_data_o !== 16'd9999) begin
            n_miss++; $display("FAIL hold_head: got val=%b data=%0d, expected val=1 data=9999", u_if.stdin_val_o, u_if.stdin_data_o);
        end
        n_vec++; if (n_pop !== p0) begin n_miss++; $display("FAIL hold_nopop: got %0d pops, expected 0", n_pop - p0); end
        u_if.stdin_rdy_i = 1'b1;
        wait_cycles(3);
        n_vec++; if (n_pop - p0 !== 3) begin n_miss++; $display("FAIL drain_count: got %0d, expected 3", n_pop - p0); end
        n_vec++; if (u_if.stdin_val_o !== 1'b0) begin n_miss++; $display("FAIL drain_empty: got val=%b, expected 0", u_if.stdin_val_o); end
    endtask

    task automatic test_errors();
        int e0;
        u_if.stdin_rdy_i = 1'b1;
        e0 = n_err;
        exp_q.push_back(16'd7);
        send_str("1234");
        send_byte("5");
        n_vec++; if (u_if.err_o !== 1'b1) begin n_miss++; $display("FAIL err_overflow_pulse: got %b, expected 1", u_if.err_o); end
        n_vec++; if (u_if.lcd_bcd_o[0] !== 4'd4 || u_if.lcd_bcd_o[3] !== 4'd1) begin
            n_miss++; $display("FAIL lcd_overflow_hold: got [3]=%0d [0]=%0d, expected [3]=1 [0]=4", u_if.lcd_bcd_o[3], u_if.lcd_bcd_o[0]);
        end
        send_str(" 7\n");
        idle_uart();
        wait_cycles(3);
        n_vec++; if (n_err - e0 !== 1) begin n_miss++; $display("FAIL err_overflow_count: got %0d, expected 1", n_err - e0); end
        e0 = n_err;
        exp_q.push_back(16'd8);
        send_str("1x2 8\n");
        idle_uart();
        wait_cycles(3);
        n_vec++; if (n_err - e0 !== 1) begin n_miss++; $display("FAIL err_other_count: got %0d, expected 1", n_err - e0); end
        n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL err_words: got %0d words pending, expected 0", exp_q.size()); end
        n_vec++; if (u_if.lcd_bcd_o[0] !== 4'd8 || u_if.lcd_bcd_o[1] !== 4'd0) begin
            n_miss++; $display("FAIL lcd_8: got [1]=%0d [0]=%0d, expected [1]=0 [0]=8", u_if.lcd_bcd_o[1], u_if.lcd_bcd_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        int a0;
        u_if.stdin_rdy_i = 1'b0;
        p0 = n_pop;
        for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i));
        send_str("1 2 3 4 ");
        n_vec++; if (u_if.uart_rdy_o !== 1'b0) begin n_miss++; $display("FAIL full_rdy: got %b, expected 0", u_if.uart_rdy_o); end
        a0 = n_acc;
        fork
            send_byte("5");
            begin
                wait_cycles(5);
                n_vec++; if (u_if.uart_rdy_o !== 1'b0 || n_acc !== a0) begin
                    n_miss++; $display("FAIL stall: got rdy=%b accepted=%0d, expected rdy=0 accepted=0", u_if.uart_rdy_o, n_acc - a0);
                end
                u_if.stdin_rdy_i = 1'b1;
                @(posedge clk_i);
                #1 u_if.stdin_rdy_i = 1'b0;
            end
        join
        n_vec++; if (n_pop - p0 !== 1) begin n_miss++; $display("FAIL stall_pop: got %0d, expected 1", n_pop - p0); end
        send_byte(" ");
        idle_uart();
        u_if.stdin_rdy_i = 1'b1;
        wait_cycles(6);
        n_vec++; if (n_pop - p0 !== 5) begin n_miss++; $display("FAIL b2b_count: got %0d, expected 5", n_pop - p0); end
        n_vec++; if (u_if.uart_rdy_o !== 1'b1) begin n_miss++; $display("FAIL b2b_rdy: got %b, expected 1", u_if.uart_rdy_o); end
    endtask

    task automatic test_eof();
        u_if.stdin_rdy_i = 1'b1;
        exp_q.push_back(16'd56);
        send_str("56");
        send_byte(ASCII_EOT);
        idle_uart();
        n_vec++; if (u_if.stdin_eof_o !== 1'b1) begin n_miss++; $display("FAIL eof_set: got %b, expected 1", u_if.stdin_eof_o); end
        n_vec++; if (u_if.stdin_val_o !== 1'b1 || u_if.stdin_data_o !== 16'd56) begin
            n_miss++; $display("FAIL eof_word: got val=%b data=%0d, expected val=1 data=56", u_if.stdin_val_o, u_if.stdin_data_o);
        end
        wait_cycles(2);
        n_vec++; if (u_if.stdin_eof_o !== 1'b1) begin n_miss++; $display("FAIL eof_sticky: got %b, expected 1", u_if.stdin_eof_o); end
        u_if.stdin_clear_i = 1'b1;
        @(posedge clk_i);
        #1 u_if.stdin_clear_i = 1'b0;
        n_vec++; if (u_if.stdin_eof_o !== 1'b0) begin n_miss++; $display("FAIL eof_clear: got %b, expected 0", u_if.stdin_eof_o); end
        u_if.stdin_clear_i = 1'b1;
        send_byte(ASCII_EOT);
        u_if.stdin_clear_i = 1'b0;
        idle_uart();
        n_vec++; if (u_if.stdin_eof_o !== 1'b1) begin n_miss++; $display("FAIL eof_set_wins: got %b, expected 1", u_if.stdin_eof_o); end
        wait_cycles(2);
        n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL eof_words: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midtoken();
        int p0;
        u_if.stdin_rdy_i = 1'b1;
        send_str("78");
        idle_uart();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        n_vec++; if (u_if.stdin_val_o !== 1'b0 || u_if.stdin_data_o !== 16'd0) begin
            n_miss++; $display("FAIL mid_rst_out: got val=%b data=%0d, expected val=0 data=0", u_if.stdin_val_o, u_if.stdin_data_o);
        end
        n_vec++; if (u_if.stdin_eof_o !== 1'b0 || u_if.err_o !== 1'b0 || u_if.uart_rdy_o !== 1'b1) begin
            n_miss++; $display("FAIL mid_rst_flags: got eof=%b err=%b rdy=%b, expected 0 0 1", u_if.stdin_eof_o, u_if.err_o, u_if.uart_rdy_o);
        end
        p0 = n_pop;
        send_str("\n");
        idle_uart();
        wait_cycles(3);
        n_vec++; if (n_pop !== p0 || u_if.stdin_val_o !== 1'b0) begin
            n_miss++; $display("FAIL mid_rst_noword: got %0d pops val=%b, expected 0 pops val=0", n_pop - p0, u_if.stdin_val_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (u_if.lcd_bcd_o[i] !== 4'd0) begin n_miss++; $display("FAIL mid_rst_lcd%0d: got %0d, expected 0", i, u_if.lcd_bcd_o[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_drain();
        test_errors();
        test_back_to_back();
        test_eof();
        test_reset_midtoken();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_miss++;
            $display("FAIL words_left: got %0d undelivered, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stdin.md
Name: stdin

Overview:
- Receive direction of the console path.
- Accepts ASCII bytes from the UART receiver and parses whitespace-separated unsigned decimal tokens into 16-bit words.
- Buffers parsed words in a small FIFO and presents them to the TOY core's stdin port with a val/rdy handshake.
- Echoes the digits being typed to the 4-digit LCD.

Parameters:
- MAX_DIGITS, 4: maximum decimal digits per token; must be ≤4 so the value stays ≤9999 and fits 16 bits.
- DEPTH, 4: word FIFO depth; must be a power of 2 and ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- uart_val_i  in  1  received byte valid
- uart_data_i  in  8  received ASCII byte
- uart_rdy_o  out  1  byte accepted when uart_val_i && uart_rdy_o
- stdin_val_o  out  1  parsed word available
- stdin_data_o  out  16  parsed word (FIFO head)
- stdin_rdy_i  in  1  core consumes word when stdin_val_o && stdin_rdy_i
- stdin_eof_o  out  1  sticky; Ctrl-D (0x04) has been received
- stdin_clear_i  in  1  clears stdin_eof_o
- err_o  out  1  one-cycle pulse when a token is discarded
- lcd_bcd_o[0:3]  out  4 each  echo digits; [0] is the least significant

Behaviour:
- Reset (clk edge with rst_ni=0):
  - state=IDLE, accumulator=0, digit count=0, FIFO emptied.
  - stdin_val_o=0, stdin_data_o=0, stdin_eof_o=0, err_o=0, all lcd_bcd_o=0.
  - uart_rdy_o=1 from the first cycle after reset.
  - A reset mid-token or mid-handshake drops everything in flight.
- Flow control: uart_rdy_o = ~fifo_full. It is a registered flag and never depends on uart_data_i. A byte is consumed only on handshake.
- Byte classes:
  - DIGIT: '0'..'9' (0x30-0x39)
  - SEP: space, '\t', '\n', '\r'
  - EOT: 0x04
  - OTHER: everything else
- States: IDLE, ACCUM, DISCARD.
- IDLE:
  - DIGIT: acc = d, cnt = 1, lcd = {0,0,0,d} (lcd[0] = d) → ACCUM.
  - SEP: ignored; stay in IDLE.
  - EOT: set eof; stay in IDLE.
  - OTHER: pulse err_o → DISCARD.
- ACCUM:
  - DIGIT with cnt < MAX_DIGITS: acc = acc*10 + d (16-bit arithmetic, no truncation possible); cnt++; lcd shifts left (lcd[3] ← lcd[2] … lcd[0] ← d).
  - DIGIT with cnt == MAX_DIGITS: pulse err_o → DISCARD. lcd is not updated.
  - SEP: push acc → IDLE.
  - EOT: push acc, set eof → IDLE.
  - OTHER: pulse err_o → DISCARD.
- DISCARD:
  - SEP: → IDLE, nothing pushed.
  - EOT: set eof → IDLE.
  - All other bytes are dropped silently, with no further err_o pulses.
- Push latency: a terminator accepted in cycle N makes the word visible on stdin_val_o/stdin_data_o in cycle N+1, provided the FIFO was empty.
- FIFO behaviour:
  - Show-ahead: stdin_data_o = head whenever stdin_val_o=1. Its value is don't-care otherwise, but is held stable.
  - Pop on stdin_val_o && stdin_rdy_i.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Push while full cannot occur, because uart_rdy_o=0.
  - Pointers wrap modulo DEPTH.
- EOF:
  - stdin_eof_o is set in the cycle after the EOT handshake.
  - stdin_clear_i clears it in the next cycle.
  - If a set and a clear occur in the same cycle, set wins.
  - EOF does not block further input or flush the FIFO.
- lcd_bcd_o keeps the last token's digits until the next token's first DIGIT.

Decomposition:
- Shared package (global.svh scope):
  - ASCII constants: ASCII_0, ASCII_9, ASCII_SP, ASCII_TAB, ASCII_LF, ASCII_CR, ASCII_EOT.
  - Parser state enum: stdin_state_e {IDLE, ACCUM, DISCARD}.
- One sub-module, stdin_fifo:
  - Parameterised DEPTH/WIDTH synchronous show-ahead FIFO.
  - Ports: push/pop/full/empty/head.
  - Synchronous active-low reset.

Test Plan:
- Bytes "123\n" back-to-back with stdin_rdy_i=1 → stdin_val_o=1 for exactly one cycle, in the cycle after '\n'; stdin_data_o=16'd123; lcd = {0,1,2,3} ([3]..[0]).
- Bytes "9999 0 42\r" with stdin_rdy_i=0 → FIFO holds 9999, 0, 42. Then raise stdin_rdy_i → words pop in order 9999, 0, 42, one per cycle.
- Bytes "12345 7\n" → err_o pulses once on the byte '5'; only word 7 is emitted. Bytes "1x2 8\n" → err_o pulses on 'x'; only word 8 is emitted.
- Five tokens "1 2 3 4 5 " with stdin_rdy_i=0 and DEPTH=4 → uart_rdy_o drops after the 4th push; byte '5' stalls until one pop, then is accepted; no word is lost.
- Bytes "56" followed by 0x04 → word 56 is pushed and stdin_eof_o=1. Pulse stdin_clear_i → stdin_eof_o=0 next cycle. Set and clear in the same cycle → stdin_eof_o stays 1.
- Assert rst_ni=0 for one edge after "78" (no terminator) and then send "\n" → no word is emitted; all outputs are at reset values; lcd = 0.
